qdi2bin_1of2_rx: RTL and testbench

- Downstream consumer for an e1of2 QDI channel, e.g. the output of a circuit under test that is driven from a binary-to-e1of2 source.
- Samples the dual-rail data rails on CLK and generates the enable back to the circuit, completing the 4-phase handshake.
- Pushes each decoded bit into a small first-word-fall-through FIFO.
- The FIFO is drained by a binary valid/ready consumer on the bench side.

---
 rtl/qdi2bin_1of2_rx.sv | 85 ++++++++
 tb/tb_qdi2bin_1of2_rx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/qdi2bin_1of2_rx.sv
// qdi2bin_1of2_rx: e1of2 QDI receiver that synchronises the rails, acknowledges via Le and queues bits in a FWFT FIFO.
// Define QDI_RX_ERR_CHECK_EN to enable the sticky protocol-error detector on err.
module qdi2bin_1of2_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [1:0]               L,
  output logic                     Le,
  output logic                     dout,
  output logic                     dvalid,
  input  logic                     dready,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     err,
  inout  wire                      VDD,
  inout  wire                      GND
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {ACCEPT, NEUTRAL} state_t;
  state_t state_q;
  logic le_q;
  logic [SYNC_STAGES-1:0][1:0] sync_q;
  logic [1:0] ls;
  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] cnt_q;
  logic onehot, full, pop, push;
  logic unused_supply;
  assign unused_supply = VDD ^ GND;
  assign ls = sync_q[SYNC_STAGES-1];
  assign onehot = ls[0] ^ ls[1];
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign pop = dvalid && dready;
  // a pop on a full FIFO frees the slot the push lands in, so both may share one edge
  assign push = (state_q == ACCEPT) && onehot && (!full || pop);
  assign Le = le_q;
  assign cnt = cnt_q;
  assign dvalid = cnt_q != '0;
  assign dout = dvalid & mem_q[rptr_q];
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], L};
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state_q <= ACCEPT;
      le_q <= 1'b1;
    end else if (state_q == ACCEPT) begin
      if (push) begin
        state_q <= NEUTRAL;
        le_q <= 1'b0;
      end
    end else if (ls == 2'b00) begin
      state_q <= ACCEPT;
      le_q <= 1'b1;
    end
  always_ff @(posedge CLK)
    if (push) mem_q[wptr_q] <= ls[1];
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wptr_q <= wptr_q + AW'(push);
      rptr_q <= rptr_q + AW'(pop);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
`ifdef QDI_RX_ERR_CHECK_EN
  logic err_q;
  logic [1:0] lsp_q;
  assign err = err_q;
  // both rails high, or a direct swap between the two data codes
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      err_q <= 1'b0;
      lsp_q <= 2'b00;
    end else begin
      lsp_q <= ls;
      if ((&ls) || (onehot && (lsp_q[0] ^ lsp_q[1]) && (ls != lsp_q))) err_q <= 1'b1;
    end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_qdi2bin_1of2_rx.sv
// tb_qdi2bin_1of2_rx: scoreboard bench for the e1of2 receiver with default SYNC_STAGES=2, DEPTH=4.
module tb_qdi2bin_1of2_rx;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] l = 2'b00;
  logic dready = 1'b0;
  logic le, dout, dvalid, err;
  logic [2:0] cnt;
  wire vdd = 1'b1;
  wire gnd = 1'b0;
  int checks = 0;
  int failures = 0;
  bit exp_q[$];
  bit rand_rdy = 1'b0;
  bit rand_phase = 1'b0;
  bit armed = 1'b0;
  logic exp_err;

  qdi2bin_1of2_rx dut (
    .CLK(clk), .RESET(rst_n), .L(l), .Le(le), .dout(dout), .dvalid(dvalid),
    .dready(dready), .cnt(cnt), .err(err), .VDD(vdd), .GND(gnd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
    if (rand_rdy) dready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_le(input logic v);
    for (int i = 0; i < 100 && le !== v; i++) cyc();
    check("le_wait", le, v);
  endtask

  task automatic send_tok(input bit b);
    l = b ? 2'b10 : 2'b01;
    exp_q.push_back(b);
    wait_le(1'b0);
    l = 2'b00;
    wait_le(1'b1);
  endtask

  // scoreboard pop and random-phase invariants, sampled mid-cycle
  always @(negedge clk) begin
    if (dvalid && dready) begin
      if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
      else check("sb_dout", dout, exp_q.pop_front());
    end
    if (rand_phase) begin
      if (armed) check("le_hold_full", le, 1);
      check("cnt_range", cnt <= DEPTH, 1);
    end
    armed = le && (cnt == DEPTH) && !dready;
  end

  initial begin
`ifdef QDI_RX_ERR_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    #12;
    check("rst_le", le, 1);
    check("rst_dvalid", dvalid, 0);
    check("rst_cnt", cnt, 0);
    check("rst_dout", dout, 0);
    check("rst_err", err, 0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    check("idle_le", le, 1);
    check("idle_dvalid", dvalid, 0);
    check("idle_cnt", cnt, 0);
    check("idle_dout", dout, 0);

    dready = 1'b1;
    l = 2'b10;
    exp_q.push_back(1'b1);
    cyc();
    check("lat_e1_le", le, 1);
    cyc();
    check("lat_e2_le", le, 1);
    cyc();
    check("lat_e3_le", le, 0);
    check("lat_e3_dvalid", dvalid, 1);
    check("lat_e3_dout", dout, 1);
    cyc();
    check("lat_e4_dvalid", dvalid, 0);
    check("lat_e4_le", le, 0);
    l = 2'b00;
    cyc();
    check("neu_e1_le", le, 0);
    cyc();
    check("neu_e2_le", le, 0);
    cyc();
    check("neu_e3_le", le, 1);

    dready = 1'b0;
    send_tok(0); send_tok(1); send_tok(1); send_tok(0);
    check("full_cnt", cnt, 4);
    l = 2'b10;
    exp_q.push_back(1'b1);
    for (int i = 0; i < 10; i++) cyc();
    check("bp_le", le, 1);
    check("bp_cnt", cnt, 4);
    dready = 1'b1;
    cyc();
    dready = 1'b0;
    check("pushpop_le", le, 0);
    check("pushpop_cnt", cnt, 4);
    l = 2'b00;
    wait_le(1'b1);
    dready = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    check("drain_cnt", cnt, 0);
    check("drain_sb", exp_q.size(), 0);

    l = 2'b11;
    for (int i = 0; i < 5; i++) cyc();
    check("e11_err", err, exp_err);
    check("e11_cnt", cnt, 0);
    check("e11_le", le, 1);
    l = 2'b00;
    for (int i = 0; i < 5; i++) cyc();
    check("e11_sticky", err, exp_err);

    dready = 1'b0;
    l = 2'b01;
    wait_le(1'b0);
    check("mid_cnt_pre", cnt, 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_le", le, 1);
    check("mid_cnt", cnt, 0);
    check("mid_dvalid", dvalid, 0);
    check("mid_dout", dout, 0);
    check("mid_err", err, 0);
    l = 2'b00;
    cyc();
    rst_n = 1'b1;
    cyc();
    check("post_le", le, 1);

    rand_rdy = 1'b1;
    rand_phase = 1'b1;
    for (int n = 0; n < 200; n++) begin
      send_tok(1'($urandom_range(0, 1)));
      for (int g = $urandom_range(0, 2); g > 0; g--) cyc();
    end
    rand_rdy = 1'b0;
    dready = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    rand_phase = 1'b0;
    check("rand_cnt", cnt, 0);
    check("rand_sb", exp_q.size(), 0);
    check("rand_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
